fpga_cfg_loader: RTL and testbench
==================================

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32: width of one bitstream input word.
REQ-002 SHALL have parameter FRAME_W, default 320: width of configs_in; equals 10 words at default WORD_W.
REQ-003 SHALL have parameter NUM_FRAMES, default 172: width of configs_en and number of frames per bitstream.
REQ-004 SHALL have parameter SETTLE_CYC, default 10: idle cycles between the last frame and ff_en assertion.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that begins a load.
REQ-008 SHALL have port cfg_data, input, WORD_W bits: bitstream word, first word = frame LSBs.
REQ-009 SHALL have port cfg_valid, input, 1 bit: cfg_data valid.
REQ-010 SHALL have port cfg_ready, output, 1 bit: loader accepts a word this cycle.
REQ-011 SHALL have port configs_in, output, FRAME_W bits: frame data to fabric.
REQ-012 SHALL have port configs_en, output, NUM_FRAMES bits: one-hot column write enable.
REQ-013 SHALL have port ff_en, output, 1 bit: fabric flip-flop enable.
REQ-014 SHALL have port rdy, output, 1 bit: configuration complete.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, APPLY, ADVANCE, SETTLE, ENABLE, DONE.
REQ-017 IDLE: on start, SHALL set configs_en=1 (bit0), word_cnt=0, frame_cnt=0, clear ff_en and rdy, and go to LOAD.
REQ-018 LOAD: cfg_ready=1; a word transfers only when cfg_valid&&cfg_ready; word k SHALL be written to shift buffer bits [k*WORD_W +: WORD_W].
REQ-019 On the transfer of word FRAME_W/WORD_W-1, the assembled frame SHALL be registered onto configs_in on the same edge, and the FSM SHALL go to APPLY.
REQ-020 APPLY: cfg_ready=0; configs_in and configs_en SHALL hold for exactly one cycle, then go to ADVANCE.
REQ-021 ADVANCE: configs_en SHALL shift left by 1 and frame_cnt SHALL increment; if frame_cnt was NUM_FRAMES-1, go to SETTLE (configs_en becomes all-zero), else go to LOAD with word_cnt=0.
REQ-022 SETTLE: SHALL count SETTLE_CYC cycles with configs_en=0, then go to ENABLE.
REQ-023 ENABLE: SHALL set ff_en=1 and go to DONE next cycle.
REQ-024 DONE: SHALL set rdy=1 one cycle after ff_en; ff_en and rdy SHALL stay high until reset or a new start.
REQ-025 start in DONE SHALL restart as from IDLE (ff_en, rdy drop on the accepting edge); start in any busy state SHALL be ignored.
REQ-026 cfg_valid outside LOAD SHALL be ignored; a word is never accepted without cfg_ready.
REQ-027 Stalls (cfg_valid low) in LOAD SHALL be tolerated indefinitely with no state change.
REQ-028 Zero-stall latency, start to rdy: NUM_FRAMES*(FRAME_W/WORD_W+2)+SETTLE_CYC+3 cycles.
REQ-029 FRAME_W SHALL be an integer multiple of WORD_W (elaboration-time check).

Reset
REQ-030 While rst=0 at a clock edge: state=IDLE, configs_in=0, configs_en=0, ff_en=0, rdy=0, busy=0, cfg_ready=0, all counters 0.
REQ-031 Reset mid-load SHALL abort immediately; no partial frame or configs_en bit survives.

Structure
REQ-032 A shared package fpga_cfg_pkg SHALL hold the state enumeration and default WORD_W/FRAME_W/NUM_FRAMES/SETTLE_CYC constants.
REQ-033 One sub-module, cfg_word_packer (word-to-frame assembly plus word counter), SHALL be used; the FSM and column shifting stay in the top.

Verification
REQ-034 Full load, cfg_valid held high, 1720 words: configs_en one-hot walks bit0..bit171; rdy rises exactly at cycle 2077 after start.
REQ-035 Frame 0 words 0x00000001..0x0000000A: configs_in==concatenation with word0 in [31:0], stable during the APPLY cycle while configs_en==1.
REQ-036 cfg_valid toggling 1/0 every cycle: identical final configs_in/configs_en sequence; only timing stretches.
REQ-037 rst=0 after frame 50's fourth word: next cycle all outputs 0, state IDLE; subsequent start reloads from frame 0.
REQ-038 start pulses during LOAD and SETTLE: ignored, frame count unchanged; start in DONE: ff_en and rdy drop, configs_en==1.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader: default geometry
// and the loader FSM state encoding.
package fpga_cfg_pkg;

    localparam int WORD_W_DEF     = 32;
    localparam int FRAME_W_DEF    = 320;
    localparam int NUM_FRAMES_DEF = 172;
    localparam int SETTLE_CYC_DEF = 10;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_APPLY   = 3'd2;
    localparam logic [2:0] ST_ADVANCE = 3'd3;
    localparam logic [2:0] ST_SETTLE  = 3'd4;
    localparam logic [2:0] ST_ENABLE  = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

endpackage

// File: rtl/cfg_word_packer.sv
// Assembles FRAME_W/WORD_W bitstream words into one frame, first word in the
// LSBs. frame_o already contains the word being pushed this cycle.
module cfg_word_packer import fpga_cfg_pkg::*; #(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [WORD_W-1:0]  word_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic               last_o
);

    localparam int WORDS = FRAME_W / WORD_W;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    logic [FRAME_W-1:0] frame_buf_q, frame_buf_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        frame_buf_d = frame_buf_q;
        word_cnt_d  = word_cnt_q;
        if (clear_i) begin
            word_cnt_d = '0;
        end else if (push_i) begin
            frame_buf_d[int'(word_cnt_q) * WORD_W +: WORD_W] = word_i;
            word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + CNT_W'(1);
        end
    end

    assign frame_o = frame_buf_d;
    assign last_o  = push_i && !clear_i && (word_cnt_q == LAST_WORD);

    always_ff @(posedge clock) begin
        if (!rst) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    // NOTE: the frame buffer has no reset; every slot is rewritten before a frame is published.
    always_ff @(posedge clock) begin
        frame_buf_q <= frame_buf_d;
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams a bitstream into the fabric one frame per column, walks a one-hot
// column enable, then waits a settle period before enabling fabric flip-flops.
module fpga_cfg_loader import fpga_cfg_pkg::*; #(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_W-1:0]     cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [FRAME_W-1:0]    configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy
);

    localparam int FC_W = $clog2(NUM_FRAMES + 1);
    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [FC_W-1:0] LAST_FRAME  = FC_W'(NUM_FRAMES - 1);
    localparam logic [SC_W-1:0] LAST_SETTLE = SC_W'(SETTLE_CYC - 1);

    generate
        if ((FRAME_W % WORD_W) != 0) begin : g_bad_frame_w
            $error("FRAME_W must be an integer multiple of WORD_W");
        end
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("SETTLE_CYC must be at least 1");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [SC_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [FRAME_W-1:0]    configs_in_q, configs_in_d;
    logic [NUM_FRAMES-1:0] configs_en_q, configs_en_d;
    logic                  ff_en_q, ff_en_d;
    logic                  rdy_q, rdy_d;

    logic                  start_accept;
    logic                  push;
    logic                  frame_last;
    logic [FRAME_W-1:0]    frame_word;

    assign start_accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign cfg_ready    = (state_q == ST_LOAD);
    assign push         = cfg_valid && cfg_ready;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);

    cfg_word_packer #(
        .WORD_W  (WORD_W),
        .FRAME_W (FRAME_W)
    ) u_packer (
        .clock   (clock),
        .rst     (rst),
        .clear_i (start_accept),
        .push_i  (push),
        .word_i  (cfg_data),
        .frame_o (frame_word),
        .last_o  (frame_last)
    );

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        settle_cnt_d = settle_cnt_q;
        configs_in_d = configs_in_q;
        configs_en_d = configs_en_q;
        ff_en_d      = ff_en_q;
        rdy_d        = rdy_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_accept) begin
                    configs_en_d = NUM_FRAMES'(1);
                    frame_cnt_d  = '0;
                    ff_en_d      = 1'b0;
                    rdy_d        = 1'b0;
                    state_d      = ST_LOAD;
                end else if (state_q == ST_DONE) begin
                    rdy_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (frame_last) begin
                    configs_in_d = frame_word;
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: state_d = ST_ADVANCE;
            ST_ADVANCE: begin
                configs_en_d = configs_en_q << 1;
                frame_cnt_d  = frame_cnt_q + FC_W'(1);
                if (frame_cnt_q == LAST_FRAME) begin
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == LAST_SETTLE) begin
                    state_d = ST_ENABLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SC_W'(1);
                end
            end
            ST_ENABLE: begin
                ff_en_d = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            settle_cnt_q <= '0;
            configs_in_q <= '0;
            configs_en_q <= '0;
            ff_en_q      <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            configs_in_q <= configs_in_d;
            configs_en_q <= configs_en_d;
            ff_en_q      <= ff_en_d;
            rdy_q        <= rdy_d;
        end
    end

    assign configs_in = configs_in_q;
    assign configs_en = configs_en_q;
    assign ff_en      = ff_en_q;
    assign rdy        = rdy_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: random bitstreams with assorted valid patterns,
// checked against a frame/column model built from the word stream.
module tb_fpga_cfg_loader;

    localparam int WORD_W         = 32;
    localparam int FRAME_W        = 320;
    localparam int NUM_FRAMES     = 172;
    localparam int SETTLE_CYC     = 10;
    localparam int WORDS          = FRAME_W / WORD_W;
    localparam int ZERO_STALL_LAT = NUM_FRAMES * (WORDS + 2) + SETTLE_CYC + 3;

    logic                  clock = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic [WORD_W-1:0]     cfg_data = '0;
    logic                  cfg_ready;
    logic [FRAME_W-1:0]    configs_in;
    logic [NUM_FRAMES-1:0] configs_en;
    logic                  ff_en;
    logic                  rdy;
    logic                  busy;
    logic [3:0]            status;

    int tests_run = 0;
    int tests_failed = 0;

    logic [WORD_W-1:0]  words [NUM_FRAMES*WORDS];
    logic [FRAME_W-1:0] apply0;
    bit                 toggle_q;
    bit                 aborted;

    fpga_cfg_loader #(
        .WORD_W     (WORD_W),
        .FRAME_W    (FRAME_W),
        .NUM_FRAMES (NUM_FRAMES),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .configs_in (configs_in),
        .configs_en (configs_en),
        .ff_en      (ff_en),
        .rdy        (rdy),
        .busy       (busy)
    );

    assign status = {cfg_ready, busy, ff_en, rdy};

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [FRAME_W-1:0] exp_frame(input int f);
        logic [FRAME_W-1:0] fr;
        fr = '0;
        for (int k = 0; k < WORDS; k++) fr[k*WORD_W +: WORD_W] = words[f*WORDS + k];
        return fr;
    endfunction

    function automatic logic [NUM_FRAMES-1:0] exp_col(input int f);
        logic [NUM_FRAMES-1:0] c;
        c = '0;
        if (f < NUM_FRAMES) c[f] = 1'b1;
        return c;
    endfunction

    task automatic fill_words(input bit marker);
        for (int i = 0; i < NUM_FRAMES*WORDS; i++) words[i] = WORD_W'($urandom);
        if (marker) for (int k = 0; k < WORDS; k++) words[k] = WORD_W'(k + 1);
    endtask

    // mode 0: valid held high, 1: valid toggles every cycle, 2: random valid
    task automatic run_load(input int mode, input bit poke_start, input int abort_f,
                            output bit was_aborted);
        int n, stalls, k, budget, n_ff;
        bit v;
        was_aborted = 1'b0;
        n = 0; stalls = 0; n_ff = -1;
        start = 1'b1;
        cfg_valid = 1'b0;
        tick(); n++;
        start = 1'b0;
        tests_run++;
        if ({status, configs_en} !== {4'b1100, exp_col(0)}) begin
            tests_failed++;
            $display("FAIL start_accept: status=%b en=%h, want status=1100 en=%h",
                     status, configs_en, exp_col(0));
        end
        for (int f = 0; f < NUM_FRAMES; f++) begin
            k = 0;
            while (k < WORDS) begin
                tests_run++;
                if ({status, configs_en} !== {4'b1100, exp_col(f)}) begin
                    tests_failed++;
                    $display("FAIL load_state f=%0d k=%0d: status=%b en=%h, want status=1100 en=%h",
                             f, k, status, configs_en, exp_col(f));
                end
                case (mode)
                    0:       v = 1'b1;
                    1:       v = toggle_q;
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                toggle_q  = ~toggle_q;
                cfg_valid = v;
                cfg_data  = v ? words[f*WORDS + k] : WORD_W'($urandom);
                if (poke_start) start = ($urandom_range(0, 15) == 0);
                tick(); n++;
                start = 1'b0;
                if (v) k++;
                else stalls++;
                if (f == abort_f && k == 4) begin
                    was_aborted = 1'b1;
                    cfg_valid = 1'b0;
                    return;
                end
            end
            // APPLY then ADVANCE; junk words offered here must be ignored
            for (int c = 0; c < 2; c++) begin
                tests_run++;
                if ({status, configs_en, configs_in} !== {4'b0100, exp_col(f), exp_frame(f)}) begin
                    tests_failed++;
                    $display("FAIL apply f=%0d c=%0d: status=%b en=%h in=%h, want status=0100 en=%h in=%h",
                             f, c, status, configs_en, configs_in, exp_col(f), exp_frame(f));
                end
                if (f == 0 && c == 0) apply0 = configs_in;
                cfg_valid = (mode == 0) ? 1'b1 : (mode == 1) ? toggle_q : 1'($urandom_range(0, 1));
                toggle_q  = ~toggle_q;
                cfg_data  = WORD_W'($urandom);
                if (poke_start) start = ($urandom_range(0, 3) == 0);
                tick(); n++;
                start = 1'b0;
            end
        end
        for (int s = 0; s < SETTLE_CYC; s++) begin
            tests_run++;
            if ({status, configs_en} !== {4'b0100, NUM_FRAMES'(0)}) begin
                tests_failed++;
                $display("FAIL settle s=%0d: status=%b en=%h, want status=0100 en=0", s, status, configs_en);
            end
            cfg_valid = 1'b1;
            cfg_data  = WORD_W'($urandom);
            if (poke_start) start = (s % 3 == 0);
            tick(); n++;
            start = 1'b0;
        end
        cfg_valid = 1'b0;
        budget = 0;
        while (rdy !== 1'b1 && budget < 64) begin
            if (ff_en === 1'b1 && n_ff < 0) n_ff = n;
            tick(); n++; budget++;
        end
        tests_run++;
        if (rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rdy_timeout: rdy=%b after %0d extra cycles, want 1", rdy, budget);
        end
        tests_run++;
        if (n !== ZERO_STALL_LAT + stalls) begin
            tests_failed++;
            $display("FAIL latency: rdy at cycle %0d, want %0d (stalls=%0d)", n, ZERO_STALL_LAT + stalls, stalls);
        end
        tests_run++;
        if (n_ff !== n - 1) begin
            tests_failed++;
            $display("FAIL ff_en_lead: ff_en first seen at cycle %0d, want %0d", n_ff, n - 1);
        end
        for (int h = 0; h < 3; h++) begin
            tests_run++;
            if ({status, configs_en} !== {4'b0011, NUM_FRAMES'(0)}) begin
                tests_failed++;
                $display("FAIL done_hold h=%0d: status=%b en=%h, want status=0011 en=0", h, status, configs_en);
            end
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data  = WORD_W'($urandom);
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start     = 1'b1;
            cfg_valid = 1'b1;
            cfg_data  = WORD_W'($urandom);
            tick();
            tests_run++;
            if ({status, configs_en, configs_in} !== '0) begin
                tests_failed++;
                $display("FAIL reset_hold i=%0d: status=%b en=%h in=%h, want all zero",
                         i, status, configs_en, configs_in);
            end
        end
        start = 1'b0;
        cfg_valid = 1'b0;
        rst = 1'b1;
        tick();
        tests_run++;
        if ({status, configs_en, configs_in} !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle: status=%b en=%h in=%h, want all zero", status, configs_en, configs_in);
        end
    endtask

    task automatic test_full_load();
        logic [FRAME_W-1:0] want0;
        fill_words(1'b1);
        run_load(0, 1'b0, -1, aborted);
        want0 = '0;
        for (int k = 0; k < WORDS; k++) want0[k*WORD_W +: WORD_W] = WORD_W'(k + 1);
        tests_run++;
        if (apply0 !== want0 || apply0[WORD_W-1:0] !== 32'h1 || apply0[FRAME_W-1 -: WORD_W] !== 32'hA) begin
            tests_failed++;
            $display("FAIL frame0_words: got %h, want %h", apply0, want0);
        end
    endtask

    task automatic test_stall_toggle();
        fill_words(1'b0);
        toggle_q = 1'b1;
        run_load(1, 1'b0, -1, aborted);
    endtask

    task automatic test_reset_midload();
        fill_words(1'b0);
        run_load(2, 1'b0, 50, aborted);
        rst = 1'b0;
        cfg_valid = 1'b1;
        tick();
        tests_run++;
        if ({status, configs_en, configs_in} !== '0) begin
            tests_failed++;
            $display("FAIL midload_abort: status=%b en=%h in=%h, want all zero", status, configs_en, configs_in);
        end
        rst = 1'b1;
        cfg_valid = 1'b0;
        tick();
        tests_run++;
        if ({status, configs_en, configs_in} !== '0) begin
            tests_failed++;
            $display("FAIL after_abort_idle: status=%b en=%h in=%h, want all zero", status, configs_en, configs_in);
        end
        fill_words(1'b0);
        run_load(2, 1'b0, -1, aborted);
    endtask

    task automatic test_start_ignored();
        fill_words(1'b0);
        run_load(0, 1'b1, -1, aborted);
    endtask

    task automatic test_restart_from_done();
        tests_run++;
        if (status !== 4'b0011) begin
            tests_failed++;
            $display("FAIL pre_restart: status=%b, want 0011", status);
        end
        fill_words(1'b0);
        run_load(2, 1'b0, -1, aborted);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_stall_toggle();
        test_reset_midload();
        test_start_ignored();
        test_restart_from_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
